// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit RAM port between the scalar core and the vector unit.
// Vector accesses are split into VLEN/64 back-to-back beats; read beats are reassembled into one response.
module mem_port_arbiter #(
  parameter int unsigned VLEN = 512,
  parameter logic [63:0] BASE = 64'h0000_0000_8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            s_req_valid,
  output logic            s_req_ready,
  input  logic            s_req_we,
  input  logic [63:0]     s_req_addr,
  input  logic [63:0]     s_req_wdata,
  input  logic [63:0]     s_req_wmask,
  output logic            s_resp_valid,
  output logic [63:0]     s_resp_rdata,
  input  logic            v_req_valid,
  output logic            v_req_ready,
  input  logic            v_req_we,
  input  logic [63:0]     v_req_addr,
  input  logic [VLEN-1:0] v_req_wdata,
  input  logic [VLEN-1:0] v_req_wmask,
  output logic            v_resp_valid,
  output logic [VLEN-1:0] v_resp_rdata,
  output logic            ram_ren,
  output logic [63:0]     ram_ridx,
  input  logic [63:0]     ram_rdata,
  output logic            ram_wen,
  output logic [63:0]     ram_widx,
  output logic [63:0]     ram_wdata,
  output logic [63:0]     ram_wmask
);

  localparam int unsigned BEATS  = VLEN / 64;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_RD  = 3'd1,
    S_WR  = 3'd2,
    V_RD  = 3'd3,
    V_WR  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  typedef logic [BEATS-1:0][63:0] beats_t;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_grant_q, last_grant_d;  // 1 = vector won last
  logic                is_vec_q, is_vec_d;
  logic [63:0]         idx_q, idx_d;
  beats_t              wdata_q, wdata_d;
  beats_t              wmask_q, wmask_d;
  logic                cap_valid_q, cap_valid_d;
  logic [BEAT_W-1:0]   cap_idx_q, cap_idx_d;
  beats_t              vbuf_q, vbuf_d;
  logic                s_resp_valid_q, s_resp_valid_d;
  logic                v_resp_valid_q, v_resp_valid_d;
  logic [63:0]         s_resp_rdata_q, s_resp_rdata_d;
  beats_t              v_resp_rdata_q, v_resp_rdata_d;

  logic idle_c, grant_vec_c, s_fire_c, v_fire_c, last_beat_c;
  logic rd_beat_c, wr_beat_c, wr_act_c;

  // Grant: sole requester wins; on a tie the side opposite the last winner wins.
  always_comb begin
    idle_c      = (state_q == IDLE) && !reset;
    grant_vec_c = v_req_valid && (!s_req_valid || !last_grant_q);
    s_fire_c    = idle_c && s_req_valid && !grant_vec_c;
    v_fire_c    = idle_c && v_req_valid && grant_vec_c;
    last_beat_c = !is_vec_q || (beat_q == LAST_BEAT);
  end

  assign s_req_ready = s_fire_c;
  assign v_req_ready = v_fire_c;

  // Next-state, request latch, read capture and response generation.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    last_grant_d   = last_grant_q;
    is_vec_d       = is_vec_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    cap_valid_d    = 1'b0;
    cap_idx_d      = beat_q;
    vbuf_d         = vbuf_q;
    s_resp_valid_d = 1'b0;
    v_resp_valid_d = 1'b0;
    s_resp_rdata_d = s_resp_rdata_q;
    v_resp_rdata_d = v_resp_rdata_q;

    // RAM data is valid the cycle after the issuing beat.
    if (cap_valid_q) begin
      vbuf_d[cap_idx_q] = ram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (s_fire_c) begin
          is_vec_d     = 1'b0;
          last_grant_d = 1'b0;
          beat_d       = '0;
          idx_d        = (s_req_addr - BASE) >> 3;
          wdata_d      = '0;
          wmask_d      = '0;
          wdata_d[0]   = s_req_wdata;
          wmask_d[0]   = s_req_wmask;
          state_d      = s_req_we ? S_WR : S_RD;
        end else if (v_fire_c) begin
          is_vec_d     = 1'b1;
          last_grant_d = 1'b1;
          beat_d       = '0;
          idx_d        = (v_req_addr - BASE) >> 3;
          wdata_d      = v_req_wdata;
          wmask_d      = v_req_wmask;
          state_d      = v_req_we ? V_WR : V_RD;
        end
      end
      S_RD, V_RD: begin
        cap_valid_d = 1'b1;
        cap_idx_d   = beat_q;
        if (last_beat_c) begin
          beat_d  = '0;
          state_d = DRAIN;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      S_WR, V_WR: begin
        if (last_beat_c) begin
          beat_d         = '0;
          state_d        = IDLE;
          s_resp_valid_d = !is_vec_q;
          v_resp_valid_d = is_vec_q;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        if (is_vec_q) begin
          v_resp_valid_d = 1'b1;
          v_resp_rdata_d = vbuf_d;
        end else begin
          s_resp_valid_d = 1'b1;
          s_resp_rdata_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port: one beat per cycle while in a read/write state; idle fields drive 0.
  always_comb begin
    rd_beat_c = (state_q == S_RD) || (state_q == V_RD);
    wr_beat_c = (state_q == S_WR) || (state_q == V_WR);
    wr_act_c  = wr_beat_c && (wmask_q[beat_q] != 64'd0);
    ram_ren   = rd_beat_c;
    ram_ridx  = rd_beat_c ? (idx_q + 64'(beat_q)) : 64'd0;
    ram_wen   = wr_act_c;
    ram_widx  = wr_act_c ? (idx_q + 64'(beat_q)) : 64'd0;
    ram_wdata = wr_act_c ? wdata_q[beat_q] : 64'd0;
    ram_wmask = wr_act_c ? wmask_q[beat_q] : 64'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      last_grant_q   <= 1'b1;
      is_vec_q       <= 1'b0;
      idx_q          <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      cap_valid_q    <= 1'b0;
      cap_idx_q      <= '0;
      vbuf_q         <= '0;
      s_resp_valid_q <= 1'b0;
      v_resp_valid_q <= 1'b0;
      s_resp_rdata_q <= '0;
      v_resp_rdata_q <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      last_grant_q   <= last_grant_d;
      is_vec_q       <= is_vec_d;
      idx_q          <= idx_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      cap_valid_q    <= cap_valid_d;
      cap_idx_q      <= cap_idx_d;
      vbuf_q         <= vbuf_d;
      s_resp_valid_q <= s_resp_valid_d;
      v_resp_valid_q <= v_resp_valid_d;
      s_resp_rdata_q <= s_resp_rdata_d;
      v_resp_rdata_q <= v_resp_rdata_d;
    end
  end

  assign s_resp_valid = s_resp_valid_q;
  assign v_resp_valid = v_resp_valid_q;
  assign s_resp_rdata = s_resp_rdata_q;
  assign v_resp_rdata = v_resp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: ready table, directed latency/corner sequences, and a
// randomized run checked against a transaction-level model of the shared port.
module tb_mem_port_arbiter;

  localparam int unsigned VLEN  = 512;
  localparam int unsigned BEATS = VLEN / 64;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic            s_req_valid, s_req_ready, s_req_we;
  logic [63:0]     s_req_addr, s_req_wdata, s_req_wmask;
  logic            s_resp_valid;
  logic [63:0]     s_resp_rdata;
  logic            v_req_valid, v_req_ready, v_req_we;
  logic [63:0]     v_req_addr;
  logic [VLEN-1:0] v_req_wdata, v_req_wmask;
  logic            v_resp_valid;
  logic [VLEN-1:0] v_resp_rdata;
  logic            ram_ren, ram_wen;
  logic [63:0]     ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.VLEN(VLEN), .BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_rdata(s_resp_rdata),
    .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_req_we(v_req_we),
    .v_req_addr(v_req_addr), .v_req_wdata(v_req_wdata), .v_req_wmask(v_req_wmask),
    .v_resp_valid(v_resp_valid), .v_resp_rdata(v_resp_rdata),
    .ram_ren(ram_ren), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_wen(ram_wen), .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask)
  );

  always #5 clock = ~clock;

  // Environment RAM: sparse, unwritten words read as a fixed hash of their index.
  logic [63:0] ram_mem [logic [63:0]];
  logic [63:0] gmem    [logic [63:0]];

  function automatic logic [63:0] init_word(input logic [63:0] i);
    return i ^ 64'hA5A5_0F0F_C3C3_9696;
  endfunction

  function automatic logic [63:0] ram_rd(input logic [63:0] i);
    if (ram_mem.exists(i)) return ram_mem[i];
    return init_word(i);
  endfunction

  function automatic logic [63:0] g_rd(input logic [63:0] i);
    if (gmem.exists(i)) return gmem[i];
    return init_word(i);
  endfunction

  always @(posedge clock) begin
    if (ram_ren) ram_rdata <= ram_rd(ram_ridx);
    else         ram_rdata <= {$urandom, $urandom};
    if (ram_wen) ram_mem[ram_widx] = (ram_rd(ram_widx) & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    s_req_valid = 0; s_req_we = 0; s_req_addr = '0; s_req_wdata = '0; s_req_wmask = '0;
    v_req_valid = 0; v_req_we = 0; v_req_addr = '0; v_req_wdata = '0; v_req_wmask = '0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [VLEN-1:0] rand_vlen();
    logic [VLEN-1:0] r;
    for (int j = 0; j < VLEN / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] rand_mask64();
    case ($urandom % 3)
      0:       return 64'd0;
      1:       return ~64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic sv, vv;
    logic exp_sr, exp_vr;
  } rdy_vec_t;

  initial begin
    rdy_vec_t    rtab [4];
    logic [VLEN-1:0] wd, wm, exp_v;
    int          grants [4];
    int          ng;

    reset = 1'b1;
    ram_rdata = '0;
    clear_inputs();

    // Ready table straight after reset (last winner = vector, so scalar wins ties).
    rtab[0] = '{sv: 0, vv: 0, exp_sr: 0, exp_vr: 0};
    rtab[1] = '{sv: 1, vv: 0, exp_sr: 1, exp_vr: 0};
    rtab[2] = '{sv: 0, vv: 1, exp_sr: 0, exp_vr: 1};
    rtab[3] = '{sv: 1, vv: 1, exp_sr: 1, exp_vr: 0};

    do_reset();
    @(negedge clock);
    chk("idle_s_ready", s_req_ready, 0);
    chk("idle_v_ready", v_req_ready, 0);
    chk("idle_s_resp", s_resp_valid, 0);
    chk("idle_v_resp", v_resp_valid, 0);
    chk("idle_ren", ram_ren, 0);
    chk("idle_wen", ram_wen, 0);
    chk("idle_ridx", ram_ridx, 0);
    chk("idle_widx", ram_widx, 0);
    chk("idle_s_rdata", s_resp_rdata, 0);
    chk("idle_v_rdata", v_resp_rdata, 0);

    foreach (rtab[i]) begin
      @(negedge clock);
      s_req_valid = rtab[i].sv;
      v_req_valid = rtab[i].vv;
      #1;
      chk($sformatf("rdy_tab%0d_s", i), s_req_ready, rtab[i].exp_sr);
      chk($sformatf("rdy_tab%0d_v", i), v_req_ready, rtab[i].exp_vr);
      s_req_valid = 0;
      v_req_valid = 0;
    end

    // Scalar read: accept c0, issue c1, data c2, response c3.
    ram_mem[64'd2] = 64'hDEAD_BEEF;
    next_cyc();
    s_req_valid = 1; s_req_we = 0; s_req_addr = BASE + 64'h10;
    @(negedge clock);
    chk("sr_accept", s_req_ready, 1);
    next_cyc();
    clear_inputs();
    @(negedge clock);
    chk("sr_c1_ren", ram_ren, 1);
    chk("sr_c1_ridx", ram_ridx, 2);
    chk("sr_c1_resp", s_resp_valid, 0);
    next_cyc();
    @(negedge clock);
    chk("sr_c2_ren", ram_ren, 0);
    chk("sr_c2_resp", s_resp_valid, 0);
    next_cyc();
    @(negedge clock);
    chk("sr_c3_resp", s_resp_valid, 1);
    chk("sr_c3_rdata", s_resp_rdata, 64'hDEAD_BEEF);
    next_cyc();
    @(negedge clock);
    chk("sr_c4_resp", s_resp_valid, 0);
    chk("sr_c4_hold", s_resp_rdata, 64'hDEAD_BEEF);

    // Vector write at word 8 with slice 3 masked off.
    wd = rand_vlen();
    wm = '1;
    wm[3*64 +: 64] = '0;
    next_cyc();
    v_req_valid = 1; v_req_we = 1; v_req_addr = BASE + 64'h40; v_req_wdata = wd; v_req_wmask = wm;
    @(negedge clock);
    chk("vw_accept", v_req_ready, 1);
    for (int k = 0; k < int'(BEATS); k++) begin
      next_cyc();
      if (k == 0) clear_inputs();
      @(negedge clock);
      chk($sformatf("vw_b%0d_wen", k), ram_wen, (k != 3));
      chk($sformatf("vw_b%0d_widx", k), ram_widx, (k != 3) ? 64'(8 + k) : 64'd0);
      if (k != 3) chk($sformatf("vw_b%0d_wdata", k), ram_wdata, wd[k*64 +: 64]);
      chk($sformatf("vw_b%0d_ren", k), ram_ren, 0);
      chk($sformatf("vw_b%0d_resp", k), v_resp_valid, 0);
    end
    next_cyc();
    @(negedge clock);
    chk("vw_c9_resp", v_resp_valid, 1);
    chk("vw_c9_wen", ram_wen, 0);
    chk("vw_skip11", ram_mem.exists(64'd11), 0);
    chk("vw_word12", ram_rd(64'd12), wd[4*64 +: 64]);

    // Vector read at word 0 with RAM word k = k+1.
    for (int k = 0; k < int'(BEATS); k++) begin
      ram_mem[64'(k)] = 64'(k + 1);
      exp_v[k*64 +: 64] = 64'(k + 1);
    end
    next_cyc();
    v_req_valid = 1; v_req_we = 0; v_req_addr = BASE;
    @(negedge clock);
    chk("vr_accept", v_req_ready, 1);
    for (int k = 0; k < int'(BEATS); k++) begin
      next_cyc();
      if (k == 0) clear_inputs();
      @(negedge clock);
      chk($sformatf("vr_b%0d_ren", k), ram_ren, 1);
      chk($sformatf("vr_b%0d_ridx", k), ram_ridx, 64'(k));
      chk($sformatf("vr_b%0d_resp", k), v_resp_valid, 0);
    end
    next_cyc();
    @(negedge clock);
    chk("vr_c9_ren", ram_ren, 0);
    chk("vr_c9_resp", v_resp_valid, 0);
    next_cyc();
    @(negedge clock);
    chk("vr_c10_resp", v_resp_valid, 1);
    chk("vr_c10_rdata", v_resp_rdata, exp_v);

    // Both requesters held valid after reset: grants alternate starting with scalar.
    do_reset();
    s_req_valid = 1; s_req_addr = BASE + 64'h100;
    v_req_valid = 1; v_req_addr = BASE + 64'h200;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clock);
      if (s_req_ready && v_req_ready) chk("alt_both_ready", 1, 0);
      if (s_req_ready) begin grants[ng] = 0; ng++; end
      else if (v_req_ready) begin grants[ng] = 1; ng++; end
      next_cyc();
    end
    clear_inputs();
    chk("alt_grant_count", ng, 4);
    for (int i = 0; i < ng; i++) chk($sformatf("alt_grant%0d", i), grants[i], i % 2);
    repeat (14) next_cyc();

    // Reset during beat 3 of a vector read drops the access.
    v_req_valid = 1; v_req_we = 0; v_req_addr = BASE;
    @(negedge clock);
    chk("rst_v_accept", v_req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      if (k == 0) clear_inputs();
    end
    reset = 1'b1;
    @(negedge clock);
    chk("rst_beat3_ridx", ram_ridx, 3);
    next_cyc();
    reset = 1'b0;
    s_req_valid = 1; s_req_we = 0; s_req_addr = BASE + 64'h18;
    @(negedge clock);
    chk("rst_next_ren", ram_ren, 0);
    chk("rst_s_accept", s_req_ready, 1);
    chk("rst_v_ready", v_req_ready, 0);
    for (int c = 6; c <= 12; c++) begin
      next_cyc();
      if (c == 6) clear_inputs();
      @(negedge clock);
      chk($sformatf("rst_c%0d_vresp", c), v_resp_valid, 0);
      if (c == 6) chk("rst_c6_ridx", ram_ridx, 3);
      if (c == 8) begin
        chk("rst_c8_sresp", s_resp_valid, 1);
        chk("rst_c8_rdata", s_resp_rdata, 64'd4);
      end
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      int free_c = 0, a_c0 = -100, a_nb = 0, p_cyc = -1, k, lat;
      logic lg_vec = 1, a_we = 0, pend = 0, p_vec = 0, p_rd = 0;
      logic [63:0] a_idx = '0;
      logic [63:0] a_wd [BEATS];
      logic [63:0] a_wm [BEATS];
      logic [VLEN-1:0] p_data = '0;
      logic e_sr, e_vr, in_beat, e_ren, e_wen;
      for (int i = 0; i < 1500; i++) begin
        s_req_valid = ($urandom % 3) != 0;
        s_req_we    = $urandom % 2;
        s_req_addr  = BASE + 64'(64 + $urandom % 32) * 8 + 64'($urandom % 8);
        s_req_wdata = {$urandom, $urandom};
        s_req_wmask = rand_mask64();
        v_req_valid = ($urandom % 3) != 0;
        v_req_we    = $urandom % 2;
        v_req_addr  = BASE + 64'(64 + $urandom % 32) * 8 + 64'($urandom % 8);
        v_req_wdata = rand_vlen();
        for (int j = 0; j < int'(BEATS); j++) v_req_wmask[j*64 +: 64] = rand_mask64();
        @(negedge clock);

        k = i - a_c0 - 1;
        in_beat = (k >= 0) && (k < a_nb);
        e_ren = in_beat && !a_we;
        e_wen = in_beat && a_we && (a_wm[k] != 64'd0);
        chk("rnd_ren", ram_ren, e_ren);
        chk("rnd_ridx", ram_ridx, e_ren ? a_idx + 64'(k) : 64'd0);
        chk("rnd_wen", ram_wen, e_wen);
        chk("rnd_widx", ram_widx, e_wen ? a_idx + 64'(k) : 64'd0);
        chk("rnd_wdata", ram_wdata, e_wen ? a_wd[k] : 64'd0);
        chk("rnd_wmask", ram_wmask, e_wen ? a_wm[k] : 64'd0);

        chk("rnd_s_resp", s_resp_valid, pend && p_cyc == i && !p_vec);
        chk("rnd_v_resp", v_resp_valid, pend && p_cyc == i && p_vec);
        if (pend && p_cyc == i) begin
          if (p_rd && p_vec)  chk("rnd_v_rdata", v_resp_rdata, p_data);
          if (p_rd && !p_vec) chk("rnd_s_rdata", s_resp_rdata, p_data);
          pend = 0;
        end

        e_sr = (i >= free_c) && s_req_valid && (!v_req_valid || lg_vec);
        e_vr = (i >= free_c) && v_req_valid && (!s_req_valid || !lg_vec);
        chk("rnd_s_ready", s_req_ready, e_sr);
        chk("rnd_v_ready", v_req_ready, e_vr);

        if (e_sr || e_vr) begin
          a_c0  = i;
          p_vec = e_vr;
          a_we  = e_vr ? v_req_we : s_req_we;
          a_idx = ((e_vr ? v_req_addr : s_req_addr) - BASE) >> 3;
          a_nb  = e_vr ? int'(BEATS) : 1;
          for (int j = 0; j < a_nb; j++) begin
            a_wd[j] = e_vr ? v_req_wdata[j*64 +: 64] : s_req_wdata;
            a_wm[j] = e_vr ? v_req_wmask[j*64 +: 64] : s_req_wmask;
          end
          p_data = '0;
          for (int j = 0; j < a_nb; j++) begin
            if (a_we) gmem[a_idx + 64'(j)] = (g_rd(a_idx + 64'(j)) & ~a_wm[j]) | (a_wd[j] & a_wm[j]);
            else      p_data[j*64 +: 64] = g_rd(a_idx + 64'(j));
          end
          lat    = a_nb + (a_we ? 1 : 2);
          p_rd   = !a_we;
          pend   = 1;
          p_cyc  = i + lat;
          free_c = p_cyc;
          lg_vec = e_vr;
        end
        next_cyc();
      end
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
